// File: rtl/pe_tile_scheduler.sv
// pe_tile_scheduler: walks (chn_out, chn) tile pairs, csync then raster scan.
// Define PE_SCHED_STALL_EN to add i_stall, which pauses the DATA scan.
module pe_tile_scheduler #(
    parameter int W_SIZE       = 16,
    parameter int W_CHANNEL    = 16,
    parameter int DRAIN_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_start,
    input  logic [W_SIZE-1:0]    i_width,
    input  logic [W_SIZE-1:0]    i_height,
    input  logic [W_CHANNEL-1:0] i_q_chn_in,
    input  logic [W_CHANNEL-1:0] i_q_chn_out,
    input  logic                 i_pe_csync_done,
`ifdef PE_SCHED_STALL_EN
    input  logic                 i_stall,
`endif
    output logic                 o_ctrl_csync_run,
    output logic                 o_ctrl_data_run,
    output logic [W_SIZE-1:0]    o_row,
    output logic [W_SIZE-1:0]    o_col,
    output logic [W_CHANNEL-1:0] o_chn,
    output logic [W_CHANNEL-1:0] o_chn_out,
    output logic                 o_is_first_row,
    output logic                 o_is_last_row,
    output logic                 o_is_first_col,
    output logic                 o_is_last_col,
    output logic [W_SIZE-1:0]    o_q_channel,
    output logic                 o_busy,
    output logic                 o_done
);
    typedef enum logic [1:0] {S_IDLE, S_CSYNC, S_DATA, S_DRAIN} state_t;

    localparam logic [W_SIZE-1:0]    ONE_S      = 1;
    localparam logic [W_CHANNEL-1:0] ONE_C      = 1;
    localparam logic [15:0]          DRAIN_LAST = 16'(DRAIN_CYCLES - 2);

    state_t                 r_state, w_state_nxt;
    logic [W_SIZE-1:0]      r_w_m1, r_h_m1, w_w_m1, w_h_m1;
    logic [W_CHANNEL-1:0]   r_qi_m1, r_qo_m1, w_qi_m1, w_qo_m1;
    logic [W_SIZE-1:0]      r_q_channel, w_q_channel;
    logic [W_SIZE-1:0]      r_row, r_col, w_row_nxt, w_col_nxt;
    logic [W_CHANNEL-1:0]   r_chn, r_chn_out, w_chn_nxt, w_chno_nxt;
    logic                   r_csync_run, r_data_run, w_csync_nxt, w_data_nxt;
    logic                   r_busy, r_done, w_busy_nxt, w_done_nxt;
    logic                   r_frow, r_lrow, r_fcol, r_lcol;
    logic [15:0]            r_cnt, w_cnt_nxt;
    logic                   w_zero_dim, w_accept, w_in_scan, w_stall;

`ifdef PE_SCHED_STALL_EN
    assign w_stall = i_stall;
`else
    assign w_stall = 1'b0;
`endif

    assign w_zero_dim = (i_width == '0) || (i_height == '0) ||
                        (i_q_chn_in == '0) || (i_q_chn_out == '0);
    assign w_accept   = (r_state == S_IDLE) && i_start && !w_zero_dim;

    // Config is captured only on an accepted start and held otherwise
    assign w_w_m1      = w_accept ? i_width - ONE_S : r_w_m1;
    assign w_h_m1      = w_accept ? i_height - ONE_S : r_h_m1;
    assign w_qi_m1     = w_accept ? i_q_chn_in - ONE_C : r_qi_m1;
    assign w_qo_m1     = w_accept ? i_q_chn_out - ONE_C : r_qo_m1;
    assign w_q_channel = w_accept ? W_SIZE'(i_q_chn_in) : r_q_channel;
    assign w_in_scan   = (w_state_nxt == S_CSYNC) || (w_state_nxt == S_DATA);

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_chn_nxt   = r_chn;
        w_chno_nxt  = r_chn_out;
        w_csync_nxt = r_csync_run;
        w_data_nxt  = 1'b0;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (i_start && w_zero_dim) begin
                    w_done_nxt = 1'b1;
                end else if (i_start) begin
                    w_state_nxt = S_CSYNC;
                    w_csync_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                    w_chn_nxt   = '0;
                    w_chno_nxt  = '0;
                end
            end
            S_CSYNC: begin
                if (i_pe_csync_done) begin
                    w_state_nxt = S_DATA;
                    w_csync_nxt = 1'b0;
                    w_data_nxt  = 1'b1;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end
            end
            S_DATA: begin
                // A presented beat is consumed; a stalled slot just waits
                w_data_nxt = !w_stall;
                if (r_data_run) begin
                    if (r_col != r_w_m1) begin
                        w_col_nxt = r_col + ONE_S;
                    end else if (r_row != r_h_m1) begin
                        w_col_nxt = '0;
                        w_row_nxt = r_row + ONE_S;
                    end else begin
                        w_data_nxt = 1'b0;
                        w_row_nxt  = '0;
                        w_col_nxt  = '0;
                        if (r_chn != r_qi_m1) begin
                            w_chn_nxt   = r_chn + ONE_C;
                            w_csync_nxt = 1'b1;
                            w_state_nxt = S_CSYNC;
                        end else if (r_chn_out != r_qo_m1) begin
                            w_chn_nxt   = '0;
                            w_chno_nxt  = r_chn_out + ONE_C;
                            w_csync_nxt = 1'b1;
                            w_state_nxt = S_CSYNC;
                        end else begin
                            w_chn_nxt   = '0;
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (r_cnt == DRAIN_LAST) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_w_m1      <= '0;
            r_h_m1      <= '0;
            r_qi_m1     <= '0;
            r_qo_m1     <= '0;
            r_q_channel <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_chn       <= '0;
            r_chn_out   <= '0;
            r_csync_run <= 1'b0;
            r_data_run  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_frow      <= 1'b0;
            r_lrow      <= 1'b0;
            r_fcol      <= 1'b0;
            r_lcol      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_w_m1      <= w_w_m1;
            r_h_m1      <= w_h_m1;
            r_qi_m1     <= w_qi_m1;
            r_qo_m1     <= w_qo_m1;
            r_q_channel <= w_q_channel;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_chn       <= w_chn_nxt;
            r_chn_out   <= w_chno_nxt;
            r_csync_run <= w_csync_nxt;
            r_data_run  <= w_data_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_frow      <= w_in_scan && (w_row_nxt == '0);
            r_lrow      <= w_in_scan && (w_row_nxt == w_h_m1);
            r_fcol      <= w_in_scan && (w_col_nxt == '0);
            r_lcol      <= w_in_scan && (w_col_nxt == w_w_m1);
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign o_ctrl_csync_run = r_csync_run;
    assign o_ctrl_data_run  = r_data_run;
    assign o_row            = r_row;
    assign o_col            = r_col;
    assign o_chn            = r_chn;
    assign o_chn_out        = r_chn_out;
    assign o_is_first_row   = r_frow;
    assign o_is_last_row    = r_lrow;
    assign o_is_first_col   = r_fcol;
    assign o_is_last_col    = r_lcol;
    assign o_q_channel      = r_q_channel;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
endmodule

// File: tb/tb_pe_tile_scheduler.sv
// Randomized bench for pe_tile_scheduler against a nested-loop tile/scan model.
module tb_pe_tile_scheduler;
    localparam int DRAIN = 15;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_start;
    logic [15:0] i_width, i_height, i_q_chn_in, i_q_chn_out;
    logic        i_pe_csync_done;
`ifdef PE_SCHED_STALL_EN
    logic        i_stall;
`endif
    logic        o_ctrl_csync_run, o_ctrl_data_run;
    logic [15:0] o_row, o_col, o_chn, o_chn_out, o_q_channel;
    logic        o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col;
    logic        o_busy, o_done;

    int n_chk  = 0;
    int n_pass = 0;

    pe_tile_scheduler dut (
        .clk              (clk),
        .rstn             (rstn),
        .i_start          (i_start),
        .i_width          (i_width),
        .i_height         (i_height),
        .i_q_chn_in       (i_q_chn_in),
        .i_q_chn_out      (i_q_chn_out),
        .i_pe_csync_done  (i_pe_csync_done),
`ifdef PE_SCHED_STALL_EN
        .i_stall          (i_stall),
`endif
        .o_ctrl_csync_run (o_ctrl_csync_run),
        .o_ctrl_data_run  (o_ctrl_data_run),
        .o_row            (o_row),
        .o_col            (o_col),
        .o_chn            (o_chn),
        .o_chn_out        (o_chn_out),
        .o_is_first_row   (o_is_first_row),
        .o_is_last_row    (o_is_last_row),
        .o_is_first_col   (o_is_first_col),
        .o_is_last_col    (o_is_last_col),
        .o_q_channel      (o_q_channel),
        .o_busy           (o_busy),
        .o_done           (o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] got,
                       input logic [95:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [95:0] beat(int co, int ci, int r, int c,
                                         int w, int h);
        logic [95:0] b;
        b = {16'(co), 16'(ci), 16'(r), 16'(c),
             r == 0, r == h - 1, c == 0, c == w - 1};
        return b;
    endfunction

    function automatic logic [95:0] obs_beat();
        return 96'({o_chn_out, o_chn, o_row, o_col, o_is_first_row,
                    o_is_last_row, o_is_first_col, o_is_last_col});
    endfunction

    function automatic logic [95:0] all_outs();
        return 96'({o_ctrl_csync_run, o_ctrl_data_run, o_row, o_col, o_chn,
                    o_chn_out, o_is_first_row, o_is_last_row, o_is_first_col,
                    o_is_last_col, o_q_channel, o_busy, o_done});
    endfunction

    task automatic quiet_inputs();
        i_start         = 1'b0;
        i_pe_csync_done = 1'b0;
`ifdef PE_SCHED_STALL_EN
        i_stall         = 1'b0;
`endif
    endtask

    task automatic run_job(input int w, input int h, input int qi,
                           input int qo, input int rst_row);
        logic [95:0] exp_q[$];
        int idx = 0, n_cs = 0, last_cyc = 0, done_cyc = 0, err = 0;
        int dly = 0, cs_age = 0;
        bit prev_cs = 0, want_dr = 0, got_done = 0, did_rst = 0;
        for (int co = 0; co < qo; co++)
            for (int ci = 0; ci < qi; ci++)
                for (int r = 0; r < h; r++)
                    for (int c = 0; c < w; c++)
                        exp_q.push_back(beat(co, ci, r, c, w, h));
        @(negedge clk);
        i_start     = 1'b1;
        i_width     = 16'(w);
        i_height    = 16'(h);
        i_q_chn_in  = 16'(qi);
        i_q_chn_out = 16'(qo);
        @(negedge clk);
        i_start = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (o_ctrl_csync_run && o_ctrl_data_run) err++;
            if (want_dr && !(o_ctrl_data_run && !o_ctrl_csync_run)) err++;
            want_dr = 1'b0;
            if (!o_done && o_busy !== 1'b1) err++;
            if (o_q_channel !== 16'(qi)) err++;
            if (o_ctrl_csync_run && !prev_cs) begin
                n_cs++;
                cs_age = 0;
                dly = $urandom_range(0, 3);
            end
            prev_cs = o_ctrl_csync_run;
            if (o_ctrl_data_run) begin
                if (idx < exp_q.size()) chk("beat", obs_beat(), exp_q[idx]);
                idx++;
                last_cyc = cyc;
                if (rst_row >= 0 && o_row == 16'(rst_row)) begin
                    did_rst = 1'b1;
                    break;
                end
            end
            if (o_done) begin
                got_done = 1'b1;
                done_cyc = cyc;
                break;
            end
            if (o_ctrl_csync_run) begin
                i_pe_csync_done = (cs_age >= dly);
                want_dr = i_pe_csync_done;
                cs_age++;
            end else begin
                i_pe_csync_done = 1'($urandom_range(0, 1));
            end
            i_start     = ($urandom_range(0, 7) == 0);
            i_width     = 16'($urandom_range(0, 6));
            i_height    = 16'($urandom_range(0, 6));
            i_q_chn_in  = 16'($urandom_range(0, 3));
            i_q_chn_out = 16'($urandom_range(0, 3));
`ifdef PE_SCHED_STALL_EN
            i_stall = ($urandom_range(0, 3) == 0);
`endif
            @(negedge clk);
        end
        quiet_inputs();
        if (did_rst) begin
            rstn = 1'b0;
            @(negedge clk);
            chk("rst_outs", all_outs(), '0);
            rstn = 1'b1;
            err = 0;
            for (int k = 0; k < 25; k++) begin
                @(negedge clk);
                if (o_done || o_busy || o_ctrl_data_run || o_ctrl_csync_run)
                    err++;
            end
            chk("rst_quiet", 96'(err), '0);
        end else begin
            chk("done_seen", 96'(got_done), 96'(1));
            chk("beats", 96'(idx), 96'(exp_q.size()));
            chk("csyncs", 96'(n_cs), 96'(qi * qo));
            chk("drain_lat", 96'(done_cyc - last_cyc), 96'(DRAIN));
            chk("proto", 96'(err), '0);
            @(negedge clk);
            chk("post_done", 96'({o_done, o_busy, o_ctrl_data_run,
                                  o_ctrl_csync_run}), '0);
        end
    endtask

    task automatic zero_job();
        int pick;
        pick = $urandom_range(0, 3);
        @(negedge clk);
        i_start     = 1'b1;
        i_width     = (pick == 0) ? 16'd0 : 16'd3;
        i_height    = (pick == 1) ? 16'd0 : 16'd2;
        i_q_chn_in  = (pick == 2) ? 16'd0 : 16'd1;
        i_q_chn_out = (pick == 3) ? 16'd0 : 16'd1;
        @(negedge clk);
        i_start = 1'b0;
        chk("zero_done", 96'({o_done, o_busy, o_ctrl_data_run,
                              o_ctrl_csync_run}), 96'(4'b1000));
        @(negedge clk);
        chk("zero_after", 96'({o_done, o_busy, o_ctrl_data_run,
                               o_ctrl_csync_run}), '0);
    endtask

    initial begin
        rstn        = 1'b0;
        i_width     = '0;
        i_height    = '0;
        i_q_chn_in  = '0;
        i_q_chn_out = '0;
        quiet_inputs();
        repeat (3) @(negedge clk);
        chk("reset", all_outs(), '0);
        rstn = 1'b1;
        run_job(3, 2, 1, 1, -1);
        run_job(2, 2, 2, 2, -1);
        zero_job();
        run_job(3, 2, 1, 1, 1);
        run_job(3, 2, 1, 1, -1);
        run_job(1, 1, 1, 1, -1);
        zero_job();
        for (int j = 0; j < 12; j++)
            run_job($urandom_range(1, 4), $urandom_range(1, 3),
                    $urandom_range(1, 3), $urandom_range(1, 2), -1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
